audio_clip_sequencer: RTL

- Playback controller that shares a single synchronous audio sample ROM between NUM_CLIPS requesters.
- Each requester owns one clip, defined by a base address, a length and a loop flag.
- Arbitrates requests by fixed priority, drives the ROM read address at a programmable sample rate and absorbs the ROM's 1-cycle registered read latency.
- Presents one registered audio sample per sample period to the DAC/PWM stage.

---
 rtl/audio_clip_sequencer_if.sv | 32 +++
 rtl/audio_clip_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/audio_clip_sequencer_if.sv
// Signal bundle between the clip sequencer and its requesters / sample ROM / DAC stage.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface audio_clip_sequencer_if #(
  parameter int AddressWidth = 10,
  parameter int DataWidth    = 8,
  parameter int NUM_CLIPS    = 4
);
  localparam int IDX_W = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1;

  logic [NUM_CLIPS-1:0]              req;
  logic [NUM_CLIPS*AddressWidth-1:0] clip_base;
  logic [NUM_CLIPS*AddressWidth-1:0] clip_len;
  logic [NUM_CLIPS-1:0]              clip_loop;
  logic                              stop;
  logic [AddressWidth-1:0]           rom_addr;
  logic [DataWidth-1:0]              rom_data;
  logic [DataWidth-1:0]              audio_out;
  logic                              sample_valid;
  logic                              busy;
  logic [IDX_W-1:0]                  active_clip;
  logic                              done;

  modport slave (
    input  req, clip_base, clip_len, clip_loop, stop, rom_data,
    output rom_addr, audio_out, sample_valid, busy, active_clip, done
  );

  modport master (
    output req, clip_base, clip_len, clip_loop, stop, rom_data,
    input  rom_addr, audio_out, sample_valid, busy, active_clip, done
  );
endinterface

// File: rtl/audio_clip_sequencer.sv
// Fixed-priority clip player sharing one registered-output sample ROM; emits one
// sample per CLK_DIV cycles and supports looping, preemption by higher priority and stop.
module audio_clip_sequencer #(
  parameter int                   AddressWidth = 10,
  parameter int                   DataWidth    = 8,
  parameter int                   NUM_CLIPS    = 4,
  parameter int                   CLK_DIV      = 1000,
  parameter int                   DIV_WIDTH    = 16,
  parameter logic [DataWidth-1:0] SILENCE      = DataWidth'(1) << (DataWidth - 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  audio_clip_sequencer_if.slave  bus
);
  localparam int IDX_W = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  logic [0:0]              state_q,  state_d;
  logic [AddressWidth-1:0] rom_addr_q, rom_addr_d;
  logic [DataWidth-1:0]    audio_q,  audio_d;
  logic                    valid_q,  valid_d;
  logic                    done_q,   done_d;
  logic [IDX_W-1:0]        active_q, active_d;
  logic [AddressWidth-1:0] base_q,   base_d;
  logic [AddressWidth-1:0] len_q,    len_d;
  logic                    loop_q,   loop_d;
  logic [DIV_WIDTH-1:0]    div_q,    div_d;
  logic [AddressWidth-1:0] smp_q,    smp_d;

  logic                    g_any;
  logic [IDX_W-1:0]        g_idx;
  logic [AddressWidth-1:0] g_base;
  logic [AddressWidth-1:0] g_len;
  logic                    g_loop;
  logic                    tick;
  logic                    last_smp;

  // Descending scan so the lowest set request index is the one left standing.
  always_comb begin
    g_any  = 1'b0;
    g_idx  = '0;
    g_base = '0;
    g_len  = '0;
    g_loop = 1'b0;
    for (int i = NUM_CLIPS - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        g_any  = 1'b1;
        g_idx  = IDX_W'(i);
        g_base = bus.clip_base[i*AddressWidth +: AddressWidth];
        g_len  = bus.clip_len[i*AddressWidth +: AddressWidth];
        g_loop = bus.clip_loop[i];
      end
    end
  end

  assign tick     = (div_q == DIV_WIDTH'(CLK_DIV - 1));
  assign last_smp = (smp_q == (len_q - AddressWidth'(1)));

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    audio_d    = audio_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    active_d   = active_q;
    base_d     = base_q;
    len_d      = len_q;
    loop_d     = loop_q;
    div_d      = div_q;
    smp_d      = smp_q;

    if (bus.stop) begin
      state_d = IDLE;
      audio_d = SILENCE;
      div_d   = '0;
      smp_d   = '0;
    end else if (state_q == IDLE) begin
      audio_d = SILENCE;
      if (g_any) begin
        active_d = g_idx;
        base_d   = g_base;
        len_d    = g_len;
        loop_d   = g_loop;
        if (g_len == '0) begin
          done_d = 1'b1;
        end else begin
          state_d    = PLAY;
          rom_addr_d = g_base;
          div_d      = '0;
          smp_d      = '0;
        end
      end
    end else if (g_any && (g_idx < active_q)) begin
      // Preemption: any pending tick is dropped and the old sample stays on audio_out.
      active_d = g_idx;
      base_d   = g_base;
      len_d    = g_len;
      loop_d   = g_loop;
      div_d    = '0;
      smp_d    = '0;
      if (g_len == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        rom_addr_d = g_base;
      end
    end else begin
      div_d = tick ? '0 : div_q + DIV_WIDTH'(1);
      if (tick) begin
        audio_d = bus.rom_data;
        valid_d = 1'b1;
        if (!last_smp) begin
          rom_addr_d = rom_addr_q + AddressWidth'(1);
          smp_d      = smp_q + AddressWidth'(1);
        end else if (loop_q) begin
          rom_addr_d = base_q;
          smp_d      = '0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      audio_q    <= SILENCE;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      active_q   <= '0;
      base_q     <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      div_q      <= '0;
      smp_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      audio_q    <= audio_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      active_q   <= active_d;
      base_q     <= base_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      div_q      <= div_d;
      smp_q      <= smp_d;
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.audio_out    = audio_q;
  assign bus.sample_valid = valid_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q == PLAY);
  assign bus.active_clip  = active_q;
endmodule
